// File: rtl/crc_checker_pkg.sv
// Shared CRC-8 definitions used by the serial generator and checker.
// Holds the CRC width, the default LFSR rule and seed, the checker FSM
// states and the LFSR next-value mode.
package crc_pkg;

  localparam int unsigned CRC_W = 8;
  localparam int unsigned CNT_W = 3;

  localparam logic [CRC_W-2:0] SHIFT_MASK_DEF = 7'b0111011;
  localparam logic [CRC_W-1:0] SEED_DEF       = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    LFSR_UPDATE = 1'b0,
    LFSR_SHIFT  = 1'b1
  } lfsr_mode_e;

endpackage

// File: rtl/crc_checker_if.sv
// Serial frame bus between the deserialiser and the CRC checker.
//   Data, Data_valid, Active : serial bit stream driven by the source
//   Busy, Done, Err          : checker status returned to the source side
interface crc_checker_if;
  logic Data;
  logic Data_valid;
  logic Active;
  logic Busy;
  logic Done;
  logic Err;

  modport master (
    output Data, Data_valid, Active,
    input  Busy, Done, Err
  );

  modport slave (
    input  Data, Data_valid, Active,
    output Busy, Done, Err
  );
endinterface

// File: rtl/crc_checker_lfsr.sv
// Combinational CRC-8 LFSR next-value function, shared with the generator.
//   l_i    : current LFSR value
//   data_i : serial input bit (used only in update mode)
//   mode_i : LFSR_UPDATE = absorb a payload bit, LFSR_SHIFT = output shift
//   l_o    : next LFSR value
module crc8_lfsr
  import crc_pkg::*;
#(
  parameter logic [CRC_W-2:0] SHIFT_MASK = SHIFT_MASK_DEF
) (
  input  logic [CRC_W-1:0] l_i,
  input  logic             data_i,
  input  lfsr_mode_e       mode_i,
  output logic [CRC_W-1:0] l_o
);

  logic fb;

  always_comb begin
    fb  = l_i[0] ^ data_i;
    l_o = l_i;
    if (mode_i == LFSR_UPDATE) begin
      l_o[CRC_W-1] = fb;
      // Mask bit 0 marks an XOR tap position.
      for (int i = 0; i < CRC_W - 1; i++) begin
        l_o[i] = l_i[i+1] ^ (fb & ~SHIFT_MASK[i]);
      end
    end else begin
      // Output shift keeps the MSB, matching the generator's CRC serialiser.
      l_o = {l_i[CRC_W-1], l_i[CRC_W-1:1]};
    end
  end

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 frame checker: recomputes the CRC over the payload bits and
// compares it bit-by-bit with the received CRC, then pulses Done with Err.
//   CLK   : clock
//   Reset : asynchronous active-low reset
//   bus   : slave side of crc_checker_if (Data/Data_valid/Active in,
//           Busy/Done/Err out, all outputs registered)
module crc_checker
  import crc_pkg::*;
#(
  parameter logic [CRC_W-2:0] SHIFT_MASK = SHIFT_MASK_DEF,
  parameter logic [CRC_W-1:0] SEED       = SEED_DEF
) (
  input  logic          CLK,
  input  logic          Reset,
  crc_checker_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CRC_W-1:0] lfsr_seed_upd, lfsr_upd, lfsr_shift;
  logic             v_pay, v_crc, bit_mis;

  // Separate instances keep every LFSR input a register or primary input.
  crc8_lfsr #(.SHIFT_MASK(SHIFT_MASK)) u_lfsr_seed (
    .l_i(SEED), .data_i(bus.Data), .mode_i(LFSR_UPDATE), .l_o(lfsr_seed_upd)
  );
  crc8_lfsr #(.SHIFT_MASK(SHIFT_MASK)) u_lfsr_upd (
    .l_i(lfsr_q), .data_i(bus.Data), .mode_i(LFSR_UPDATE), .l_o(lfsr_upd)
  );
  crc8_lfsr #(.SHIFT_MASK(SHIFT_MASK)) u_lfsr_shift (
    .l_i(lfsr_q), .data_i(bus.Data), .mode_i(LFSR_SHIFT), .l_o(lfsr_shift)
  );

  assign v_pay   = bus.Data_valid & bus.Active;
  assign v_crc   = bus.Data_valid & ~bus.Active;
  assign bit_mis = bus.Data ^ lfsr_q[0];

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (v_pay) begin
          lfsr_d  = lfsr_seed_upd;
          state_d = DATA;
        end
      end
      DATA: begin
        if (v_pay) begin
          lfsr_d = lfsr_upd;
        end else if (v_crc) begin
          mis_d   = mis_q | bit_mis;
          lfsr_d  = lfsr_shift;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (v_pay) begin
          // Truncated CRC: fail this frame, the bit starts the next one.
          done_d  = 1'b1;
          err_d   = 1'b1;
          lfsr_d  = lfsr_seed_upd;
          cnt_d   = '0;
          mis_d   = 1'b0;
          state_d = DATA;
        end else if (v_crc) begin
          mis_d  = mis_q | bit_mis;
          lfsr_d = lfsr_shift;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CRC_W - 1)) begin
            done_d  = 1'b1;
            err_d   = mis_q | bit_mis;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        lfsr_d  = SEED;
        cnt_d   = '0;
        mis_d   = 1'b0;
        state_d = IDLE;
        // Back-to-back frame: first payload bit may land here.
        if (v_pay) begin
          lfsr_d  = lfsr_seed_upd;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Err  = err_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: table of frames plus hand sequences for
// back-to-back, abort and mid-frame reset.
module tb_crc_checker;

  logic CLK;
  logic Reset;

  crc_checker_if bus ();

  crc_checker dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         npay;
    logic [7:0] pay;     // payload bits, bit 0 sent first
    logic [7:0] crc;     // received CRC, bit 0 sent first
    logic       err;     // expected Err
    int         stall_p; // invalid cycles after payload bit 0
    int         stall_c; // invalid cycles after CRC bit 3
  } vec_t;

  vec_t vecs[5];

  int nvec;
  int miscmp;
  int cyc;
  int done_cnt;
  int last_done_cyc;
  logic last_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit after the posedge.
  task automatic step(input logic v, input logic a, input logic d);
    @(negedge CLK);
    bus.Data_valid = v;
    bus.Active     = a;
    bus.Data       = d;
    @(posedge CLK);
    #1;
    cyc++;
    if (bus.Done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_err      = bus.Err;
    end
  endtask

  task automatic send_frame(input int npay, input logic [7:0] pay, input logic [7:0] crc,
                            input int stall_p, input int stall_c);
    for (int i = 0; i < npay; i++) begin
      step(1'b1, 1'b1, pay[i]);
      if (i == 0) repeat (stall_p) step(1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, crc[i]);
      // Active high with valid low must not be taken as an abort.
      if (i == 3) repeat (stall_c) step(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    int c0;
    logic [7:0] crc_c4;

    nvec = 0; miscmp = 0; cyc = 0; done_cnt = 0; last_done_cyc = 0; last_err = 1'b0;
    crc_c4 = 8'hC4;

    vecs[0] = '{npay: 1, pay: 8'h01, crc: 8'hC4, err: 1'b0, stall_p: 0, stall_c: 0};
    vecs[1] = '{npay: 2, pay: 8'h03, crc: 8'hA6, err: 1'b0, stall_p: 0, stall_c: 0};
    vecs[2] = '{npay: 2, pay: 8'h03, crc: 8'hAE, err: 1'b1, stall_p: 0, stall_c: 0};
    vecs[3] = '{npay: 2, pay: 8'h01, crc: 8'h62, err: 1'b0, stall_p: 3, stall_c: 3};
    vecs[4] = '{npay: 1, pay: 8'h01, crc: 8'hC5, err: 1'b1, stall_p: 0, stall_c: 0};

    Reset = 1'b0;
    bus.Data = 1'b0; bus.Data_valid = 1'b0; bus.Active = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_err",  32'(bus.Err),  32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // CRC-phase bits while idle are ignored.
    done_cnt = 0;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("idle_ignore_busy", 32'(bus.Busy), 32'd0);
    check("idle_ignore_done", 32'(done_cnt), 32'd0);

    for (int k = 0; k < 5; k++) begin
      done_cnt = 0;
      c0 = cyc;
      send_frame(vecs[k].npay, vecs[k].pay, vecs[k].crc, vecs[k].stall_p, vecs[k].stall_c);
      check($sformatf("vec%0d_done_cnt", k), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_done_cyc", k), 32'(last_done_cyc - c0),
            32'(vecs[k].npay + 8 + vecs[k].stall_p + vecs[k].stall_c));
      check($sformatf("vec%0d_err", k), 32'(last_err), 32'(vecs[k].err));
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d_single_pulse", k), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_idle_busy", k), 32'(bus.Busy), 32'd0);
      check($sformatf("vec%0d_err_hold", k), 32'(bus.Err), 32'(vecs[k].err));
    end

    // Back-to-back: frame 2 starts in frame 1's DONE cycle.
    done_cnt = 0;
    c0 = cyc;
    send_frame(1, 8'h01, 8'hC4, 0, 0);
    check("b2b_first_done", 32'(last_done_cyc - c0), 32'd9);
    check("b2b_first_err",  32'(last_err), 32'd0);
    send_frame(2, 8'h03, 8'hA6, 0, 0);
    check("b2b_done_cnt",    32'(done_cnt), 32'd2);
    check("b2b_second_done", 32'(last_done_cyc - c0), 32'd19);
    check("b2b_second_err",  32'(last_err), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Abort after 4 CRC bits; the aborting bit is payload of the next frame.
    done_cnt = 0;
    c0 = cyc;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, crc_c4[i]);
    step(1'b1, 1'b1, 1'b1);
    check("abort_done_cnt", 32'(done_cnt), 32'd1);
    check("abort_done_cyc", 32'(last_done_cyc - c0), 32'd6);
    check("abort_err",      32'(last_err), 32'd1);
    check("abort_busy",     32'(bus.Busy), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, crc_c4[i]);
    check("after_abort_done_cnt", 32'(done_cnt), 32'd2);
    check("after_abort_done_cyc", 32'(last_done_cyc - c0), 32'd14);
    check("after_abort_err",      32'(last_err), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // Leave Err high, then reset in the middle of the CRC phase.
    send_frame(2, 8'h03, 8'hAE, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    check("pre_reset_err", 32'(bus.Err), 32'd1);
    done_cnt = 0;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, crc_c4[i]);
    check("pre_reset_busy", 32'(bus.Busy), 32'd1);
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.Busy), 32'd0);
    check("midreset_done", 32'(bus.Done), 32'd0);
    check("midreset_err",  32'(bus.Err),  32'd0);
    // Remaining CRC bits while in reset must be discarded.
    for (int i = 3; i < 8; i++) step(1'b1, 1'b0, crc_c4[i]);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    c0 = cyc;
    send_frame(1, 8'h01, 8'hC4, 0, 0);
    check("post_reset_done_cnt", 32'(done_cnt), 32'd1);
    check("post_reset_done_cyc", 32'(last_done_cyc - c0), 32'd9);
    check("post_reset_err",      32'(last_err), 32'd0);
    step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscmp);
    $finish;
  end

endmodule
